// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding, constants and bus-width helper for the sa1 sequencer.
package sa_pkg;
   typedef enum logic [2:0] {IDLE, WFILL, WLOAD, STREAM, DRAIN, DONE} state_t;
   localparam logic DATA_SEL_WEIGHT = 1'b1;
   function automatic int bussize(input int size);
      return size + 16;
   endfunction
endpackage

// File: rtl/sa_valid_pipe.sv
// sa_valid_pipe: shift register of {valid,last} tags tracking vectors in flight through the array.
module sa_valid_pipe #(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic in_last,
   output logic tail_valid,
   output logic tail_last,
   output logic empty
);
   logic [DEPTH-1:0] v_q, v_d, l_q, l_d;
   always_comb begin
      v_d = (v_q << 1) | DEPTH'(in_valid);
      l_d = (l_q << 1) | DEPTH'(in_valid & in_last);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         l_q <= '0;
      end else begin
         v_q <= v_d;
         l_q <= l_d;
      end
   end
   assign tail_valid = v_q[DEPTH-1];
   assign tail_last  = l_q[DEPTH-1];
   assign empty      = ~|v_q;
endmodule

// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: buffers a weight tile, shifts it into the sa1 array, streams activations
// and returns each column-result vector with valid/last once the array latency has elapsed.
module sa_seq_ctrl
   import sa_pkg::*;
#(
   parameter int SIZE     = 4,
   parameter int PIPE_LAT = 8,
   parameter int CNT_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [CNT_W-1:0]            num_vec,
   output logic                        busy,
   output logic                        done,
   input  logic                        w_valid,
   output logic                        w_ready,
   input  logic [8*SIZE-1:0]           w_data,
   input  logic                        a_valid,
   output logic                        a_ready,
   input  logic [8*SIZE-1:0]           a_data,
   output logic                        sa_data_sel,
   output logic [8*SIZE-1:0]           sa_data,
   input  logic [SIZE*bussize(SIZE)-1:0] sa_result,
   output logic                        r_valid,
   output logic [SIZE*bussize(SIZE)-1:0] r_data,
   output logic                        r_last
);
   localparam int DW   = 8 * SIZE;
   localparam int RW   = SIZE * bussize(SIZE);
   localparam int WC_W = SIZE > 1 ? $clog2(SIZE) : 1;
   localparam logic [WC_W-1:0] W_LAST = WC_W'(SIZE - 1);

   state_t            state_q, state_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d;
   logic [CNT_W-1:0]  vcnt_q, vcnt_d, num_q, num_d;
   logic [DW-1:0]     wbuf_q [SIZE];
   logic [DW-1:0]     wbuf_d [SIZE];
   logic [DW-1:0]     sa_data_q, sa_data_d;
   logic [RW-1:0]     r_data_q, r_data_d;
   logic              sel_q, sel_d, push_v_q, push_v_d, push_l_q, push_l_d;
   logic              r_valid_q, r_valid_d, r_last_q, r_last_d, done_q, done_d;
   logic              w_acc, a_acc, last_acc, tail_valid, tail_last, pipe_empty;

   assign w_ready  = state_q == WFILL;
   assign a_ready  = state_q == STREAM && vcnt_q < num_q;
   assign w_acc    = w_valid & w_ready;
   assign a_acc    = a_valid & a_ready;
   assign last_acc = a_acc && vcnt_q == num_q - CNT_W'(1);

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      vcnt_d  = vcnt_q;
      num_d   = num_q;
      wbuf_d  = wbuf_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = WFILL;
            num_d   = num_vec;
            wcnt_d  = '0;
            vcnt_d  = '0;
         end
         WFILL: if (w_acc) begin
            wbuf_d[wcnt_q] = w_data;
            wcnt_d  = wcnt_q == W_LAST ? '0 : wcnt_q + WC_W'(1);
            state_d = wcnt_q == W_LAST ? WLOAD : WFILL;
         end
         WLOAD: begin
            wcnt_d  = wcnt_q == W_LAST ? '0 : wcnt_q + WC_W'(1);
            state_d = wcnt_q != W_LAST ? WLOAD : num_q == '0 ? DONE : STREAM;
         end
         STREAM: if (a_acc) begin
            vcnt_d  = vcnt_q + CNT_W'(1);
            state_d = last_acc ? DRAIN : STREAM;
         end
         // the final result has left the array once r_last is on the output register
         DRAIN:   state_d = pipe_empty && r_valid_q && r_last_q ? DONE : DRAIN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      sel_d     = state_q == WLOAD ? DATA_SEL_WEIGHT : ~DATA_SEL_WEIGHT;
      sa_data_d = state_q == WLOAD ? wbuf_q[wcnt_q] : a_acc ? a_data : '0;
      push_v_d  = a_acc;
      push_l_d  = last_acc;
      r_valid_d = tail_valid;
      r_last_d  = tail_valid & tail_last;
      r_data_d  = tail_valid ? sa_result : r_data_q;
      done_d    = state_d == DONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wcnt_q    <= '0;
         vcnt_q    <= '0;
         num_q     <= '0;
         sa_data_q <= '0;
         sel_q     <= 1'b0;
         push_v_q  <= 1'b0;
         push_l_q  <= 1'b0;
         r_valid_q <= 1'b0;
         r_last_q  <= 1'b0;
         r_data_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         vcnt_q    <= vcnt_d;
         num_q     <= num_d;
         sa_data_q <= sa_data_d;
         sel_q     <= sel_d;
         push_v_q  <= push_v_d;
         push_l_q  <= push_l_d;
         r_valid_q <= r_valid_d;
         r_last_q  <= r_last_d;
         r_data_q  <= r_data_d;
         done_q    <= done_d;
      end
   end

   always_ff @(posedge clk) wbuf_q <= wbuf_d;

   // tags enter alongside sa_data, so the tail lines up with the stable sa_result
   sa_valid_pipe #(.DEPTH(PIPE_LAT)) u_pipe (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (push_v_q),
      .in_last    (push_l_q),
      .tail_valid (tail_valid),
      .tail_last  (tail_last),
      .empty      (pipe_empty)
   );

   assign busy        = state_q != IDLE;
   assign done        = done_q;
   assign sa_data_sel = sel_q;
   assign sa_data     = sa_data_q;
   assign r_valid     = r_valid_q;
   assign r_data      = r_data_q;
   assign r_last      = r_last_q;
endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb_sa_seq_ctrl: tile scenarios from a table plus random tiles, checked against a
// queue model of accepted vectors and their expected result times.
module tb_sa_seq_ctrl;
   import sa_pkg::*;
   localparam int SIZE = 4, PIPE_LAT = 8, CNT_W = 16;
   localparam int DW = 8 * SIZE, RW = SIZE * bussize(SIZE);

   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [CNT_W-1:0] num_vec = '0;
   logic busy, done, w_ready, a_ready, sa_data_sel, r_valid, r_last;
   logic w_valid = 1'b0, a_valid = 1'b0;
   logic [DW-1:0] w_data = '0, a_data = '0, sa_data;
   logic [RW-1:0] sa_result, r_data;
   logic [DW-1:0] hist [PIPE_LAT];

   always #5 clk = ~clk;

   sa_seq_ctrl #(.SIZE(SIZE), .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .sa_data_sel(sa_data_sel), .sa_data(sa_data), .sa_result(sa_result),
      .r_valid(r_valid), .r_data(r_data), .r_last(r_last)
   );

   // array stand-in: result is the input vector PIPE_LAT cycles later
   always @(posedge clk) begin
      for (int i = PIPE_LAT - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= sa_data;
   end
   assign sa_result = RW'(hist[PIPE_LAT-1]);

   typedef struct {int t; logic [DW-1:0] d; bit last;} exp_t;
   typedef struct {int nv; int gap_at; int gap_len; bit w_tog; bit poke; int exp_res;} vec_t;
   exp_t exp_q[$];
   logic [DW-1:0] wrow_q[$], wseen_q[$];
   int checks = 0, errs = 0, cyc = 0;
   int tile_nv, acc_n, res_n, done_n, sel_n, first_sel, last_sel, last_wacc, last_r;
   bit pend;
   logic [DW-1:0] pend_d;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errs++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   task automatic monitor();
      bit ev;
      if (w_valid && w_ready) begin
         wrow_q.push_back(w_data);
         last_wacc = cyc + 1;
      end
      if (!sa_data_sel) chk("sa_data", 128'(sa_data), pend ? 128'(pend_d) : 128'(0));
      else begin
         if (sel_n == 0) first_sel = cyc;
         last_sel = cyc;
         sel_n++;
         wseen_q.push_back(sa_data);
      end
      pend   = a_valid && a_ready;
      pend_d = a_data;
      if (pend) begin
         acc_n++;
         exp_q.push_back('{cyc + 1, a_data, acc_n == tile_nv});
      end
      ev = exp_q.size() > 0 && exp_q[0].t + PIPE_LAT + 1 == cyc;
      chk("r_valid", 128'(r_valid), 128'(ev));
      if (ev) begin
         chk("r_data", 128'(r_data), 128'(RW'(exp_q[0].d)));
         chk("r_last", 128'(r_last), 128'(exp_q[0].last));
         if (exp_q[0].last) last_r = cyc;
         res_n++;
         void'(exp_q.pop_front());
      end
      if (done) begin
         done_n++;
         if (tile_nv > 0) chk("done_time", 128'(cyc), 128'(last_r + 1));
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic new_tile(input int nv);
      tile_nv = nv; acc_n = 0; res_n = 0; done_n = 0; sel_n = 0;
      first_sel = -1; last_sel = -1; last_wacc = 0; last_r = -100;
      wrow_q.delete();
      wseen_q.delete();
   endtask

   task automatic begin_tile(input int nv, input bit w_tog);
      int n;
      bit acc;
      new_tile(nv);
      start = 1'b1;
      num_vec = CNT_W'(nv);
      step();
      start = 1'b0;
      num_vec = CNT_W'($urandom);
      for (int r = 0; r < SIZE; r++) begin
         acc = 1'b0;
         n = 0;
         w_data = DW'($urandom);
         while (!acc && n < 50) begin
            w_valid = 1'b1;
            acc = w_ready;
            step();
            n++;
         end
         if (!acc) timeout("w_accept");
         w_valid = 1'b0;
         if (w_tog) step();
      end
   endtask

   task automatic run_tile(input vec_t v);
      int n;
      bit acc;
      begin_tile(v.nv, v.w_tog);
      for (int i = 0; i < v.nv; i++) begin
         if (i == v.gap_at) repeat (v.gap_len) step();
         a_data = DW'($urandom);
         a_valid = 1'b1;
         acc = 1'b0;
         n = 0;
         while (!acc && n < 100) begin
            acc = a_ready;
            if (v.poke && i == 1) begin
               start = 1'b1;
               num_vec = CNT_W'(v.nv + 5);
            end
            step();
            start = 1'b0;
            n++;
         end
         if (!acc) timeout("a_accept");
         a_valid = 1'b0;
      end
      n = 0;
      while (done_n == 0 && n < 200) begin
         step();
         n++;
      end
      if (done_n == 0) timeout("done");
      step();
      chk("busy_after", 128'(busy), 128'(0));
      chk("results", 128'(res_n), 128'(v.exp_res));
      chk("pending", 128'(exp_q.size()), 128'(0));
      chk("done_count", 128'(done_n), 128'(1));
      chk("sel_cycles", 128'(sel_n), 128'(SIZE));
      chk("sel_run", 128'(last_sel - first_sel), 128'(SIZE - 1));
      chk("wload_after_fill", 128'(first_sel > last_wacc), 128'(1));
      for (int r = 0; r < SIZE; r++)
         chk("weight_row", 128'(r < wseen_q.size() ? wseen_q[r] : 'x), 128'(wrow_q[r]));
   endtask

   vec_t tbl [5];

   initial begin
      bit acc;
      int n;
      tbl[0] = '{3, 0, 0, 1'b0, 1'b0, 3};
      tbl[1] = '{3, 2, 2, 1'b0, 1'b0, 3};
      tbl[2] = '{3, 0, 0, 1'b1, 1'b0, 3};
      tbl[3] = '{0, 0, 0, 1'b0, 1'b0, 0};
      tbl[4] = '{4, 0, 0, 1'b0, 1'b1, 4};
      new_tile(0);
      pend = 1'b0;
      step();
      step();
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_w_ready", 128'(w_ready), 128'(0));
      chk("rst_a_ready", 128'(a_ready), 128'(0));
      chk("rst_sel", 128'(sa_data_sel), 128'(0));
      chk("rst_r_valid", 128'(r_valid), 128'(0));
      chk("rst_r_data", 128'(r_data), 128'(0));
      rst = 1'b0;
      step();
      for (int i = 0; i < 5; i++) run_tile(tbl[i]);
      for (int i = 0; i < 6; i++) begin
         vec_t v;
         v.nv = $urandom_range(1, 6);
         v.gap_at = $urandom_range(0, 5);
         v.gap_len = $urandom_range(0, 3);
         v.w_tog = 1'($urandom_range(0, 1));
         v.poke = 1'($urandom_range(0, 1));
         v.exp_res = v.nv;
         run_tile(v);
      end
      // abort two cycles into the activation stream
      begin_tile(5, 1'b0);
      a_valid = 1'b1;
      a_data = DW'($urandom);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         acc = a_ready;
         step();
         n++;
      end
      if (!acc) timeout("abort_stream");
      step();
      rst = 1'b1;
      #1;
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_done", 128'(done), 128'(0));
      chk("abort_a_ready", 128'(a_ready), 128'(0));
      chk("abort_sel", 128'(sa_data_sel), 128'(0));
      chk("abort_sa_data", 128'(sa_data), 128'(0));
      chk("abort_r_valid", 128'(r_valid), 128'(0));
      chk("abort_r_last", 128'(r_last), 128'(0));
      chk("abort_r_data", 128'(r_data), 128'(0));
      a_valid = 1'b0;
      pend = 1'b0;
      exp_q.delete();
      new_tile(0);
      step();
      rst = 1'b0;
      repeat (30) step();
      chk("abort_no_done", 128'(done_n), 128'(0));
      chk("abort_no_result", 128'(res_n), 128'(0));
      run_tile(tbl[0]);
      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end
endmodule
